// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet TX path: FSM encoding, default
// sizing constants and requester indices.
package eth_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_SEND  = 2'd2,
        ST_IFG   = 2'd3
    } tx_state_t;

    localparam int IFG_BYTES_DEF     = 12;
    localparam int MAX_FRAME_DEF     = 1536;
    localparam int START_TIMEOUT_DEF = 64;

    localparam int REQ_ARP = 0;
    localparam int REQ_UDP = 1;

    // Per-frame byte counter width; saturates rather than wrapping.
    localparam int BYTE_CNT_W = 11;

endpackage

// File: rtl/eth_tx_arbiter_rr_pick2.sv
// Two-way round-robin selector: on contention the requester that was not
// served last wins; a lone request is always picked. Purely combinational.
module rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_pick
);

    // Pick the requester other than i_last on contention, else pass through.
    always_comb begin
        o_pick = i_req;
        if (i_req == 2'b11) begin
            o_pick = i_last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/eth_tx_arbiter.sv
// Frame-granular arbiter sharing the GMII TX byte path between the ARP
// sender (requester 0) and the UDP sender (requester 1). Whole frames are
// granted round-robin, followed by an inter-frame gap. A watchdog revokes
// grants that never start and a guard truncates oversize frames.
module eth_tx_arbiter
    import eth_pkg::*;
#(
    parameter int IFG_BYTES       = IFG_BYTES_DEF,
    parameter int START_TIMEOUT   = START_TIMEOUT_DEF,
    parameter int MAX_FRAME_BYTES = MAX_FRAME_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt,
    input  logic [1:0] src_tx_en,
    input  logic [7:0] src_txd0,
    input  logic [7:0] src_txd1,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       busy,
    output logic       err_timeout,
    output logic       err_trunc
);

    localparam int WAIT_W = $clog2(START_TIMEOUT + 1);
    localparam int IFG_W  = $clog2(IFG_BYTES + 1);

    tx_state_t              r_state,    w_state_nxt;
    logic [1:0]             r_gnt,      w_gnt_nxt;
    logic                   r_tx_en,    w_tx_en_nxt;
    logic [7:0]             r_txd,      w_txd_nxt;
    logic                   r_last,     w_last_nxt;
    logic                   r_err_to,   w_err_to_nxt;
    logic                   r_err_tr,   w_err_tr_nxt;
    logic [WAIT_W-1:0]      r_wait_cnt, w_wait_cnt_nxt;
    logic [BYTE_CNT_W-1:0]  r_byte_cnt, w_byte_cnt_nxt;
    logic [IFG_W-1:0]       r_ifg_cnt,  w_ifg_cnt_nxt;

    logic [1:0] w_pick;
    logic       w_sel;
    logic       w_sel_en;
    logic [7:0] w_sel_d;

    rr_pick2 u_pick (
        .i_req  (req),
        .i_last (r_last),
        .o_pick (w_pick)
    );

    // Only the granted source is looked at; the other is fully masked.
    assign w_sel    = r_gnt[REQ_UDP];
    assign w_sel_en = src_tx_en[w_sel];
    assign w_sel_d  = w_sel ? src_txd1 : src_txd0;

    assign gnt         = r_gnt;
    assign gmii_tx_en  = r_tx_en;
    assign gmii_txd    = r_txd;
    assign busy        = (r_state != ST_IDLE);
    assign err_timeout = r_err_to;
    assign err_trunc   = r_err_tr;

    // State and registered outputs; reset restarts cleanly with no gap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= 2'b00;
            r_tx_en    <= 1'b0;
            r_txd      <= 8'h00;
            r_last     <= 1'b1;
            r_err_to   <= 1'b0;
            r_err_tr   <= 1'b0;
            r_wait_cnt <= '0;
            r_byte_cnt <= '0;
            r_ifg_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_tx_en    <= w_tx_en_nxt;
            r_txd      <= w_txd_nxt;
            r_last     <= w_last_nxt;
            r_err_to   <= w_err_to_nxt;
            r_err_tr   <= w_err_tr_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_ifg_cnt  <= w_ifg_cnt_nxt;
        end
    end

    // Next-state logic and the values the output registers load next.
    always_comb begin
        w_state_nxt    = r_state;
        w_gnt_nxt      = r_gnt;
        w_tx_en_nxt    = 1'b0;
        w_txd_nxt      = 8'h00;
        w_last_nxt     = r_last;
        w_err_to_nxt   = 1'b0;
        w_err_tr_nxt   = 1'b0;
        w_wait_cnt_nxt = r_wait_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_ifg_cnt_nxt  = r_ifg_cnt;

        unique case (r_state)
            ST_IDLE: begin
                if (|req) begin
                    w_state_nxt    = ST_GRANT;
                    w_gnt_nxt      = w_pick;
                    w_wait_cnt_nxt = '0;
                end
            end

            ST_GRANT: begin
                if (w_sel_en) begin
                    // First byte is forwarded straight away.
                    w_state_nxt    = ST_SEND;
                    w_tx_en_nxt    = 1'b1;
                    w_txd_nxt      = w_sel_d;
                    w_byte_cnt_nxt = BYTE_CNT_W'(1);
                end else if (!req[w_sel]) begin
                    // Requester withdrew before sending: nothing went out,
                    // so no gap is owed.
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = 2'b00;
                end else if (r_wait_cnt == WAIT_W'(START_TIMEOUT - 1)) begin
                    w_state_nxt  = ST_IDLE;
                    w_gnt_nxt    = 2'b00;
                    w_err_to_nxt = 1'b1;
                    w_last_nxt   = w_sel;
                end else begin
                    w_wait_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end

            ST_SEND: begin
                if (w_sel_en && (r_byte_cnt == BYTE_CNT_W'(MAX_FRAME_BYTES))) begin
                    // Oversize frame: cut it here, the tail is dropped.
                    w_state_nxt   = ST_IFG;
                    w_gnt_nxt     = 2'b00;
                    w_err_tr_nxt  = 1'b1;
                    w_last_nxt    = w_sel;
                    w_ifg_cnt_nxt = '0;
                end else if (w_sel_en) begin
                    w_tx_en_nxt = 1'b1;
                    w_txd_nxt   = w_sel_d;
                    if (r_byte_cnt != '1) begin
                        w_byte_cnt_nxt = r_byte_cnt + 1'b1;
                    end
                end else begin
                    w_state_nxt   = ST_IFG;
                    w_gnt_nxt     = 2'b00;
                    w_last_nxt    = w_sel;
                    w_ifg_cnt_nxt = '0;
                end
            end

            ST_IFG: begin
                if (r_ifg_cnt == IFG_W'(IFG_BYTES - 1)) begin
                    // A waiting request goes straight to GRANT.
                    if (|req) begin
                        w_state_nxt    = ST_GRANT;
                        w_gnt_nxt      = w_pick;
                        w_wait_cnt_nxt = '0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_ifg_cnt_nxt = r_ifg_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// Scoreboard bench for eth_tx_arbiter. Source drivers push each byte they
// expect to see forwarded; a negedge monitor pops and compares every byte
// the arbiter emits and tracks gaps, burst lengths and error pulses.
module tb_eth_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] req;
    logic [1:0] gnt;
    logic [1:0] src_tx_en;
    logic [7:0] src_txd0;
    logic [7:0] src_txd1;
    logic       gmii_tx_en;
    logic [7:0] gmii_txd;
    logic       busy;
    logic       err_timeout;
    logic       err_trunc;

    logic       s_req [2];
    logic       s_en  [2];
    logic [7:0] s_d   [2];

    assign req       = {s_req[1], s_req[0]};
    assign src_tx_en = {s_en[1], s_en[0]};
    assign src_txd0  = s_d[0];
    assign src_txd1  = s_d[1];

    eth_tx_arbiter #(
        .IFG_BYTES       (12),
        .START_TIMEOUT   (64),
        .MAX_FRAME_BYTES (1536)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .src_tx_en   (src_tx_en),
        .src_txd0    (src_txd0),
        .src_txd1    (src_txd1),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_txd    (gmii_txd),
        .busy        (busy),
        .err_timeout (err_timeout),
        .err_trunc   (err_trunc)
    );

    always #4 clk = ~clk;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];

    int   run_low    = 0;
    int   last_gap   = 0;
    int   burst      = 0;
    int   last_burst = 0;
    int   trunc_cnt  = 0;
    logic [1:0] trunc_gnt  = 2'b00;
    logic       trunc_busy = 1'b0;
    logic       ff_seen    = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: compare forwarded bytes, measure bursts/gaps, log error pulses.
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (gmii_txd == 8'hFF) ff_seen = 1'b1;
            if (err_trunc) begin
                trunc_cnt++;
                trunc_gnt  = gnt;
                trunc_busy = busy;
            end
            if (gmii_tx_en) begin
                if (run_low > 0) begin
                    last_gap = run_low;
                    run_low  = 0;
                end
                burst++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_extra: got byte %0h expected none at %0t", gmii_txd, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_byte", int'(gmii_txd), int'(e));
                end
            end else begin
                if (burst > 0) begin
                    last_burst = burst;
                    burst      = 0;
                end
                run_low++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            s_req[i] = 1'b0;
            s_en[i]  = 1'b0;
            s_d[i]   = 8'h00;
        end
        step();
        step();
        rst = 1'b0;
    endtask

    // Source model: request, wait for grant, start one cycle after seeing it
    // (registered source), drop req with the first byte, push expected bytes.
    task automatic send_frame(input int idx, input int n, input int base,
                              input bit chk_lat, input int max_expect);
        int t;
        logic [7:0] b;
        s_req[idx] = 1'b1;
        if (chk_lat) begin
            step();
            check("gnt_latency", int'(gnt), (idx == 0) ? 1 : 2);
        end
        t = 0;
        while (!gnt[idx] && t < 5000) begin
            step();
            t++;
        end
        if (!gnt[idx]) begin
            checks++;
            errors++;
            $display("FAIL gnt_wait: got gnt=%0d expected bit %0d set", gnt, idx);
            s_req[idx] = 1'b0;
            return;
        end
        step();
        for (int i = 0; i < n; i++) begin
            b         = 8'(base + i);
            s_en[idx] = 1'b1;
            s_d[idx]  = b;
            if (i < max_expect) exp_q.push_back(b);
            if (i == 0) s_req[idx] = 1'b0;
            step();
            if (chk_lat && i == 0)
                check("data_latency", int'({gmii_tx_en, gmii_txd}), int'({1'b1, 8'(base)}));
        end
        s_en[idx] = 1'b0;
        s_d[idx]  = 8'h00;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        for (int i = 0; i < 2; i++) begin
            s_req[i] = 1'b0;
            s_en[i]  = 1'b0;
            s_d[i]   = 8'h00;
        end

        // Reset state
        do_reset();
        check("rst_gnt",   int'(gnt), 0);
        check("rst_txen",  int'(gmii_tx_en), 0);
        check("rst_txd",   int'(gmii_txd), 0);
        check("rst_busy",  int'(busy), 0);
        check("rst_err",   int'({err_timeout, err_trunc}), 0);

        // Single ARP frame, 64 bytes 0x00..0x3F
        send_frame(0, 64, 'h00, 1'b1, 64);
        repeat (3) step();
        check("arp_len", last_burst, 64);
        check("arp_ifg", int'({busy, gnt}), 4);

        // Both requesting from reset: ARP first, then UDP after a 14-cycle gap
        do_reset();
        fork
            send_frame(0, 64, 'h10, 1'b1, 64);
            send_frame(1, 64, 'h80, 1'b0, 64);
        join
        repeat (3) step();
        check("rr_gap", last_gap, 14);
        check("rr_len", last_burst, 64);

        // Start timeout on UDP, pending ARP granted right after
        do_reset();
        s_req[1] = 1'b1;
        step();
        check("to_gnt", int'(gnt), 2);
        s_req[0] = 1'b1;
        bad = 0;
        repeat (63) begin
            step();
            if (err_timeout || gnt != 2'b10) bad++;
        end
        check("to_early", bad, 0);
        step();
        check("to_pulse", int'(err_timeout), 1);
        check("to_gnt_clr", int'(gnt), 0);
        step();
        check("to_regrant", int'(gnt), 1);
        check("to_pulse_end", int'(err_timeout), 0);
        s_req[0] = 1'b0;
        s_req[1] = 1'b0;
        repeat (3) step();

        // Oversize UDP frame truncated at 1536 bytes
        do_reset();
        trunc_cnt = 0;
        send_frame(1, 1600, 'h00, 1'b0, 1536);
        repeat (3) step();
        check("trunc_cnt", trunc_cnt, 1);
        check("trunc_len", last_burst, 1536);
        check("trunc_ifg", int'({trunc_gnt, trunc_busy}), 1);

        // Reset in the middle of a frame
        do_reset();
        s_req[0] = 1'b1;
        step();
        step();
        for (int i = 0; i < 20; i++) begin
            s_en[0] = 1'b1;
            s_d[0]  = 8'(8'h40 + i);
            exp_q.push_back(8'(8'h40 + i));
            step();
        end
        rst     = 1'b1;
        s_d[0]  = 8'h54;
        step();
        check("mid_rst_txen", int'(gmii_tx_en), 0);
        check("mid_rst_gnt", int'(gnt), 0);
        rst      = 1'b0;
        s_en[0]  = 1'b0;
        s_req[0] = 1'b0;
        s_req[1] = 1'b1;
        step();
        check("post_rst_gnt", int'(gnt), 2);
        s_req[1] = 1'b0;
        step();
        step();
        check("post_rst_idle", int'(busy), 0);

        // Non-granted source toggling 0xFF during an ARP frame
        do_reset();
        ff_seen = 1'b0;
        fork
            send_frame(0, 100, 'h20, 1'b0, 100);
            begin
                repeat (130) begin
                    s_en[1] = ~s_en[1];
                    s_d[1]  = 8'hFF;
                    step();
                end
                s_en[1] = 1'b0;
                s_d[1]  = 8'h00;
            end
        join
        repeat (3) step();
        check("noise_ff", int'(ff_seen), 0);
        check("noise_len", last_burst, 100);

        repeat (5) step();
        check("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_arbiter.md
Name: eth_tx_arbiter

Overview:
- Frame-granular two-way arbiter sharing one GMII byte transmit path (before the RGMII DDR output stage) between the ARP sender (requester 0) and the UDP sender (requester 1).
- Grants whole frames, round-robin on contention.
- Enforces the Ethernet inter-frame gap, a start-timeout watchdog and a maximum-frame truncation guard.
- Output is registered and drives the RGMII TX serializer directly.

Parameters:
- IFG_BYTES, 12, idle cycles the arbiter holds off between frames (byte clock).
- START_TIMEOUT, 64, cycles a granted requester has to raise its tx_en before the grant is revoked.
- MAX_FRAME_BYTES, 1536, maximum bytes forwarded per frame before truncation.

Ports:
- clk  in  1  125 MHz GMII byte clock.
- rst  in  1  synchronous reset, active-high.
- req  in  2  per-requester frame request; bit0 = ARP, bit1 = UDP.
- gnt  out  2  one-hot grant, registered.
- src_tx_en  in  2  per-requester byte valid.
- src_txd0  in  8  requester 0 byte.
- src_txd1  in  8  requester 1 byte.
- gmii_tx_en  out  1  arbitrated byte valid, registered.
- gmii_txd  out  8  arbitrated byte, registered.
- busy  out  1  high in any state other than IDLE.
- err_timeout  out  1  one-cycle pulse when a grant is revoked by the watchdog.
- err_trunc  out  1  one-cycle pulse when a frame is truncated.

Behaviour:
- One clock; reset is synchronous and active-high (ports clk, rst).
- Reset values:
  - gnt=0, gmii_tx_en=0, gmii_txd=0, busy=0, err_*=0.
  - State IDLE; round-robin pointer last=1, so ARP wins the first contention.
  - All counters 0.
- States: IDLE, GRANT, SEND, IFG.
- IDLE:
  - Any req bit high -> GRANT next cycle; gnt asserted that cycle (1-cycle latency from req).
  - Both bits high -> grant the index != last.
  - Single bit high -> grant it.
- GRANT:
  - Selected src_tx_en high -> SEND; the first byte is captured this cycle.
  - Selected req low with src_tx_en low -> IDLE, gnt cleared; no IFG, nothing was sent.
  - Wait counter reaches START_TIMEOUT -> IDLE, gnt cleared, err_timeout pulse; last = timed-out index.
- SEND:
  - gmii_tx_en/gmii_txd = selected src_tx_en/src_txd, registered one cycle. Input-to-output latency exactly 1 cycle.
  - Non-selected inputs are ignored entirely.
  - req may drop during SEND; the grant holds until selected src_tx_en is low. That cycle -> IFG, gnt cleared, last = selected index.
  - Byte counter reaches MAX_FRAME_BYTES with src_tx_en still high -> force gmii_tx_en=0 next cycle, err_trunc pulse, -> IFG, gnt cleared. Remaining source bytes are discarded.
  - Byte counter is 11 bits and saturates; it never wraps.
- IFG:
  - Lasts exactly IFG_BYTES cycles; gmii_tx_en=0 throughout.
  - On the final IFG cycle, pending req -> GRANT directly, skipping IDLE; otherwise -> IDLE.
  - Minimum gmii_tx_en low gap between frames = IFG_BYTES+2 cycles.
- Simultaneous events:
  - A req arriving during SEND/IFG waits; it is never lost while held.
  - src_tx_en from a non-granted requester never reaches the output.
- Reset mid-frame: gmii_tx_en drops the cycle after rst is sampled high; all state is reinitialised; no IFG is enforced after reset.
- Invariants:
  - gnt is zero or one-hot.
  - gnt never changes while in SEND.

Decomposition:
- Shared package eth_pkg holds:
  - State encoding for IDLE/GRANT/SEND/IFG.
  - Default constants IFG_BYTES_DEF=12, MAX_FRAME_DEF=1536.
  - Requester index constants REQ_ARP=0, REQ_UDP=1.
- One natural sub-module: rr_pick2. Combinational two-way round-robin selector (req, last -> one-hot pick), reused by future RX-side arbiters.

Test Plan:
- Single ARP frame, 64 bytes 0x00..0x3F:
  - gnt=01 one cycle after req.
  - gmii_txd equals source delayed 1 cycle; 64 valid cycles; then IFG.
- Both req high from reset:
  - ARP is granted first.
  - After its frame, UDP is granted; gmii_tx_en low gap = 14 cycles exactly (IFG_BYTES=12).
- Requester 1 granted, never raises src_tx_en:
  - err_timeout pulses 64 cycles after grant; gnt=00.
  - Pending req0 is granted next cycle, since last=1.
- UDP frame 1600 bytes with MAX_FRAME_BYTES=1536:
  - Exactly 1536 bytes appear on gmii; err_trunc pulses once.
  - Source bytes 1537..1600 never appear; IFG follows.
- rst asserted at byte 20 of a frame:
  - gmii_tx_en=0 and gnt=00 on the next cycle.
  - After release, a new req is granted one cycle later with no IFG wait.
- Non-granted src_tx_en toggling with 0xFF during another frame: no 0xFF ever appears on gmii_txd.
